alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Two-entry registered output buffer directly downstream of the 32-bit ALU (adder/subtractor, SLT, logic units). Captures each ALU result with its flags, destination tag and ALU command, then presents them in order to the writeback stage over a valid/ready handshake. It normalises flags for SLT, whose carry/overflow come from an internal subtraction and must not leak to writeback. It also keeps a sticky overflow status bit.

## Interface
- WIDTH, 32, data width of result.
- TAG_W, 5, destination register tag width.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  buffer can accept; registered.
- in_op  in  3  ALU command that produced the result.
- in_result  in  WIDTH  ALU result.
- in_carryout, in_zero, in_overflow  in  1 each  ALU flags.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts head.
- out_result  out  WIDTH; out_carryout, out_zero, out_overflow  out  1 each; out_tag  out  TAG_W; out_op  out  3  head entry fields.
- sticky_overflow  out  1  set when an entry with overflow is popped.
- clear_sticky  in  1  synchronous clear of sticky_overflow.

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Strict FIFO order, depth 2.
- Capture rule for in_op == SLT (3):
  - out_carryout = 0 and out_overflow = 0 are stored.
  - out_zero is recomputed as (in_result == 0). The input zero flag is ignored.
  - in_result is stored unchanged. Upstream guarantees bits [WIDTH-1:1] are 0.
- All other ops: flags are stored as received.
- Occupancy: 2-bit count, values 0..2. Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
- in_ready = (count < 2), registered from next-state count.
- Full (count 2): in_ready = 0, so no push. A pop that cycle makes count 1 and in_ready = 1 next cycle.
- Empty (count 0): out_valid = 0. Output data fields hold their last values. The bench must not check them while out_valid = 0.
- Pointers: 1-bit read and write pointers, wrapping 1→0.
- sticky_overflow:
  - Set on a pop whose entry has out_overflow = 1.
  - Cleared by clear_sticky.
  - Set and clear in the same cycle: set wins.
- Out-of-protocol in_valid while in_ready = 0 is ignored; no state change.

## Timing
- Reset values, asynchronous on reset_n low: count 0, pointers 0, out_valid 0, in_ready 1, sticky_overflow 0, all output data fields 0.
- Reset mid-operation discards all entries immediately. out_valid falls without waiting for a clock edge.
- Latency: a push into an empty buffer gives out_valid = 1 on the next cycle, with that entry's fields.
- Throughput: 1 entry per cycle when out_ready is held high. Push and pop of the same entry never occur in the same cycle.
- out_* fields are stable while out_valid && !out_ready.
- in_ready depends only on registered state; there is no combinational path from out_ready.

## Structure
- Shared package alu_defs_pkg holds:
  - ALU command constants: ADD 0, SUB 1, XOR 2, SLT 3, AND 4, NAND 5, NOR 6, OR 7.
  - ALU_OP_W = 3.
  - A packed entry type {op, tag, result, carryout, zero, overflow}.
- The ALU and this buffer both import alu_defs_pkg.
- One sub-module, alu_flag_normalize: combinational, applies the SLT flag rule before storage. Instantiated once on the push path.
- Storage is two entry registers plus pointers, inline in alu_result_buffer.

## Test plan
- Reset with in_valid = 1 held → out_valid 0, in_ready 1, sticky 0. First push after release → out_valid the next cycle.
- Push ADD result 0x0000_0005, carry 1, tag 3; out_ready = 1 → next cycle out_result 0x5, out_carryout 1, out_tag 3. out_valid drops the cycle after.
- Push SLT with result 0x0000_0000, zero 0, overflow 1, carry 1 → out_zero 1, out_overflow 0, out_carryout 0. A second SLT with result 0x1 → out_zero 0.
- out_ready = 0, push three entries (tags 1, 2, 3) on consecutive cycles → in_ready 0 after the second push, the third is ignored. Raise out_ready → tags 1 then 2, then out_valid 0.
- Full buffer, simultaneous pop and an in_valid attempt → count 1, in_ready 1 next cycle, no entry lost or duplicated. Then continuous push/pop for 10 cycles → tags emerge in order with no bubbles.
- Pop an entry with overflow 1 → sticky_overflow 1. Assert clear_sticky in the same cycle as another overflow pop → stays 1. clear_sticky alone → 0. Assert reset_n low with 2 entries held → out_valid 0 and sticky 0 immediately.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: command encodings, widths and the packed result entry
// exchanged between the ALU and its writeback buffer.
package alu_defs_pkg;

    localparam int ALU_OP_W   = 3;
    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_TAG_W-1:0]  tag;
        logic [ALU_DATA_W-1:0] result;
        logic                  carryout;
        logic                  zero;
        logic                  overflow;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_normalize.sv
// Flag cleanup on the buffer push path: SLT flags come from an internal subtract
// and are replaced; every other command passes its flags through untouched.
module alu_flag_normalize
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = ALU_DATA_W
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    result,
    input  logic                carryout,
    input  logic                zero,
    input  logic                overflow,
    output logic                norm_carryout,
    output logic                norm_zero,
    output logic                norm_overflow
);

    logic is_slt;

    always_comb begin
        is_slt        = (op == ALU_SLT);
        norm_carryout = carryout;
        norm_zero     = zero;
        norm_overflow = overflow;
        if (is_slt) begin
            norm_carryout = 1'b0;
            norm_overflow = 1'b0;
            norm_zero     = (result == '0);
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Two-entry in-order buffer between the ALU and writeback, with registered
// head outputs, registered in_ready and a sticky overflow status bit.
module alu_result_buffer
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = ALU_DATA_W,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_op,
    input  logic [WIDTH-1:0]    in_result,
    input  logic                in_carryout,
    input  logic                in_zero,
    input  logic                in_overflow,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_result,
    output logic                out_carryout,
    output logic                out_zero,
    output logic                out_overflow,
    output logic [TAG_W-1:0]    out_tag,
    output logic [ALU_OP_W-1:0] out_op,
    output logic                sticky_overflow,
    input  logic                clear_sticky
);

    logic [1:0] count_reg, count_next;
    logic       wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic       out_valid_reg, in_ready_reg, sticky_reg;
    logic       push, pop;
    logic       norm_carryout, norm_zero, norm_overflow;
    alu_entry_t entry_reg [2];
    alu_entry_t head_reg, head_next, push_entry;

    alu_flag_normalize #(.WIDTH(WIDTH)) u_norm (
        .op            (in_op),
        .result        (in_result),
        .carryout      (in_carryout),
        .zero          (in_zero),
        .overflow      (in_overflow),
        .norm_carryout (norm_carryout),
        .norm_zero     (norm_zero),
        .norm_overflow (norm_overflow)
    );

    always_comb begin
        push_entry          = '0;
        push_entry.op       = in_op;
        push_entry.tag      = in_tag;
        push_entry.result   = in_result;
        push_entry.carryout = norm_carryout;
        push_entry.zero     = norm_zero;
        push_entry.overflow = norm_overflow;
    end

    // Handshakes only look at registered state, so in_ready never depends on out_ready.
    assign push = in_valid && in_ready_reg;
    assign pop  = out_valid_reg && out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    assign rd_ptr_next = rd_ptr_reg ^ pop;

    // Next head: a slot written this cycle is not yet in entry_reg, so bypass it.
    always_comb begin
        if (push && (wr_ptr_reg == rd_ptr_next))
            head_next = push_entry;
        else
            head_next = entry_reg[rd_ptr_next];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            sticky_reg    <= 1'b0;
            head_reg      <= '0;
            for (int i = 0; i < 2; i++)
                entry_reg[i] <= '0;
        end else begin
            count_reg     <= count_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_reg ^ push;
            out_valid_reg <= (count_next != 2'd0);
            in_ready_reg  <= (count_next < 2'd2);
            if (push)
                entry_reg[wr_ptr_reg] <= push_entry;
            // Data outputs keep their last value once the buffer drains.
            if (count_next != 2'd0)
                head_reg <= head_next;
            if (pop && head_reg.overflow)
                sticky_reg <= 1'b1;
            else if (clear_sticky)
                sticky_reg <= 1'b0;
        end
    end

    assign in_ready        = in_ready_reg;
    assign out_valid       = out_valid_reg;
    assign out_result      = head_reg.result;
    assign out_carryout    = head_reg.carryout;
    assign out_zero        = head_reg.zero;
    assign out_overflow    = head_reg.overflow;
    assign out_tag         = head_reg.tag;
    assign out_op          = head_reg.op;
    assign sticky_overflow = sticky_reg;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: directed pushes queue hand-computed
// entries, a negedge monitor compares every popped head against the queue.
module tb_alu_result_buffer;
    import alu_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_result;
    logic        in_carryout, in_zero, in_overflow;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_carryout, out_zero, out_overflow;
    logic [4:0]  out_tag;
    logic [2:0]  out_op;
    logic        sticky_overflow, clear_sticky;

    int total = 0;
    int bad   = 0;
    alu_entry_t sb[$];

    alu_result_buffer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_result       (in_result),
        .in_carryout     (in_carryout),
        .in_zero         (in_zero),
        .in_overflow     (in_overflow),
        .in_tag          (in_tag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_carryout    (out_carryout),
        .out_zero        (out_zero),
        .out_overflow    (out_overflow),
        .out_tag         (out_tag),
        .out_op          (out_op),
        .sticky_overflow (sticky_overflow),
        .clear_sticky    (clear_sticky)
    );

    always #5 clk = ~clk;

    function automatic alu_entry_t mk(input logic [2:0] op, input logic [4:0] tag,
                                      input logic [31:0] res, input logic c,
                                      input logic z, input logic v);
        alu_entry_t e;
        e.op = op; e.tag = tag; e.result = res;
        e.carryout = c; e.zero = z; e.overflow = v;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one transfer attempt; only accepted pushes enter the scoreboard.
    task automatic push(input alu_entry_t drv, input alu_entry_t exp, input logic accept);
        in_op       = drv.op;
        in_tag      = drv.tag;
        in_result   = drv.result;
        in_carryout = drv.carryout;
        in_zero     = drv.zero;
        in_overflow = drv.overflow;
        in_valid    = 1'b1;
        check($sformatf("accept_tag%0d", drv.tag), {63'd0, in_ready}, {63'd0, accept});
        if (in_ready)
            sb.push_back(exp);
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted head is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                alu_entry_t got, exp;
                got = mk(out_op, out_tag, out_result, out_carryout, out_zero, out_overflow);
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got=%0h expected=none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL pop_entry got=%0h expected=%0h", got, exp);
                    end else begin
                        $display("pop tag=%0d op=%0d result=%h c=%b z=%b v=%b",
                                 got.tag, got.op, got.result, got.carryout, got.zero, got.overflow);
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; clear_sticky = 1'b0;
        in_op = 3'd0; in_result = 32'd0; in_carryout = 1'b0; in_zero = 1'b0;
        in_overflow = 1'b0; in_tag = 5'd0;
        step(); step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_sticky", {63'd0, sticky_overflow}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();

        // ADD latency, then drain
        push(mk(3'd0, 5'd3, 32'h5, 1'b1, 1'b0, 1'b0), mk(3'd0, 5'd3, 32'h5, 1'b1, 1'b0, 1'b0), 1'b1);
        check("latency_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        step();
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // SLT flag normalisation
        push(mk(3'd3, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1), mk(3'd3, 5'd7, 32'h0, 1'b0, 1'b1, 1'b0), 1'b1);
        push(mk(3'd3, 5'd8, 32'h1, 1'b1, 1'b1, 1'b1), mk(3'd3, 5'd8, 32'h1, 1'b0, 1'b0, 1'b0), 1'b1);
        step(); step();
        check("slt_no_sticky", {63'd0, sticky_overflow}, 64'd0);

        // Fill with out_ready low; third push must be refused
        out_ready = 1'b0;
        push(mk(3'd2, 5'd1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0), mk(3'd2, 5'd1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0), 1'b1);
        push(mk(3'd4, 5'd2, 32'h0000_F00F, 1'b0, 1'b0, 1'b0), mk(3'd4, 5'd2, 32'h0000_F00F, 1'b0, 1'b0, 1'b0), 1'b1);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        push(mk(3'd7, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0), mk(3'd7, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0), 1'b0);
        out_ready = 1'b1;
        step(); step();
        check("fill_drained_valid", {63'd0, out_valid}, 64'd0);
        check("fill_sb_empty", 64'(sb.size()), 64'd0);

        // Full buffer: pop while an in_valid attempt is refused
        out_ready = 1'b0;
        push(mk(3'd1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0), mk(3'd1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0), 1'b1);
        push(mk(3'd1, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0), mk(3'd1, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0), 1'b1);
        out_ready = 1'b1;
        push(mk(3'd0, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0), mk(3'd0, 5'd6, 32'h66, 1'b0, 1'b0, 1'b0), 1'b0);
        check("pop_full_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            push(mk(3'd6, 5'(8 + i), 32'(i * 3), 1'b0, 1'b0, 1'b0),
                 mk(3'd6, 5'(8 + i), 32'(i * 3), 1'b0, 1'b0, 1'b0), 1'b1);
            check($sformatf("stream_valid%0d", i), {63'd0, out_valid}, 64'd1);
        end
        step(); step();
        check("stream_drained_valid", {63'd0, out_valid}, 64'd0);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Sticky overflow set / set-beats-clear / clear
        push(mk(3'd0, 5'd20, 32'h8000_0000, 1'b0, 1'b0, 1'b1), mk(3'd0, 5'd20, 32'h8000_0000, 1'b0, 1'b0, 1'b1), 1'b1);
        step();
        check("sticky_set", {63'd0, sticky_overflow}, 64'd1);
        push(mk(3'd1, 5'd21, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1), mk(3'd1, 5'd21, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1), 1'b1);
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        check("sticky_set_wins", {63'd0, sticky_overflow}, 64'd1);
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        check("sticky_cleared", {63'd0, sticky_overflow}, 64'd0);
        push(mk(3'd0, 5'd24, 32'h1, 1'b0, 1'b0, 1'b1), mk(3'd0, 5'd24, 32'h1, 1'b0, 1'b0, 1'b1), 1'b1);
        step();
        check("sticky_reset_pre", {63'd0, sticky_overflow}, 64'd1);

        // Reset with two entries held
        out_ready = 1'b0;
        push(mk(3'd0, 5'd22, 32'h22, 1'b0, 1'b0, 1'b0), mk(3'd0, 5'd22, 32'h22, 1'b0, 1'b0, 1'b0), 1'b1);
        push(mk(3'd0, 5'd23, 32'h23, 1'b0, 1'b0, 1'b0), mk(3'd0, 5'd23, 32'h23, 1'b0, 1'b0, 1'b0), 1'b1);
        check("held_valid", {63'd0, out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_sticky", {63'd0, sticky_overflow}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        push(mk(3'd5, 5'd25, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0), mk(3'd5, 5'd25, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0), 1'b1);
        check("post_rst_latency", {63'd0, out_valid}, 64'd1);
        step(); step();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
